// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache answering 64-byte line reads as 8 x 64-bit beats.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   reqcyc/reqack/req/reqtag    core line-read request (reqack combinational, IDLE only)
//   respcyc/respack/resp/resptag  core response beats, ascending address order
//   mem_reqcyc/mem_reqack/mem_req/mem_reqtag  fill request toward memory
//   mem_respcyc/mem_respack/mem_resp          fill beats from memory
module icache_responder #(
  parameter int LINES = 64,
  parameter int TAG_W = 13,
  parameter int BEATS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqcyc,
  output logic             reqack,
  input  logic [63:0]      req,
  input  logic [TAG_W-1:0] reqtag,
  output logic             respcyc,
  input  logic             respack,
  output logic [63:0]      resp,
  output logic [TAG_W-1:0] resptag,
  output logic             mem_reqcyc,
  input  logic             mem_reqack,
  output logic [63:0]      mem_req,
  output logic [TAG_W-1:0] mem_reqtag,
  input  logic             mem_respcyc,
  output logic             mem_respack,
  input  logic [63:0]      mem_resp
);
  localparam int IDX  = $clog2(LINES);
  localparam int AT_W = 58 - IDX;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_FILL, S_RESPOND} state_t;

  state_t           r_state;
  logic [63:0]      r_addr;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_k;
  logic [LINES-1:0] r_valid;
  logic [511:0]     r_line;
  logic             r_respcyc;
  logic [63:0]      r_resp;
  logic [TAG_W-1:0] r_resptag;
  logic             r_mem_reqcyc;
  logic [63:0]      r_mem_req;
  logic [TAG_W-1:0] r_mem_reqtag;
  logic [AT_W-1:0]  r_tags [LINES];
  logic [511:0]     r_data [LINES];
  logic [IDX-1:0]   w_idx;
  logic             w_hit;
  logic             w_last;

  assign w_idx       = r_addr[6 +: IDX];
  assign w_hit       = r_valid[w_idx] && r_tags[w_idx] == r_addr[63 -: AT_W];
  assign w_last      = r_k == 3'(BEATS - 1);
  assign reqack      = reqcyc && r_state == S_IDLE;
  assign mem_respack = mem_respcyc && r_state == S_MISS_FILL;
  assign respcyc     = r_respcyc;
  assign resp        = r_resp;
  assign resptag     = r_resptag;
  assign mem_reqcyc  = r_mem_reqcyc;
  assign mem_req     = r_mem_req;
  assign mem_reqtag  = r_mem_reqtag;

  // Arrays carry no reset; only the valid bits define line presence.
  // The tag is written alongside the last fill beat.
  always_ff @(posedge clk) begin
    if (mem_respack) begin
      r_data[w_idx][{r_k, 6'b0} +: 64] <= mem_resp;
      if (w_last) r_tags[w_idx] <= r_addr[63 -: AT_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_tag        <= '0;
      r_k          <= '0;
      r_valid      <= '0;
      r_line       <= '0;
      r_respcyc    <= 1'b0;
      r_resp       <= '0;
      r_resptag    <= '0;
      r_mem_reqcyc <= 1'b0;
      r_mem_req    <= '0;
      r_mem_reqtag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (reqack) begin
            r_addr  <= req & ~64'h3f;
            r_tag   <= reqtag;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_line    <= r_data[w_idx];
            r_resp    <= r_data[w_idx][63:0];
            r_resptag <= r_tag;
            r_respcyc <= 1'b1;
            r_k       <= '0;
            r_state   <= S_RESPOND;
          end else begin
            r_mem_reqcyc <= 1'b1;
            r_mem_req    <= r_addr;
            r_mem_reqtag <= r_tag;
            r_state      <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (mem_reqack) begin
            r_mem_reqcyc <= 1'b0;
            r_k          <= '0;
            r_state      <= S_MISS_FILL;
          end
        end
        S_MISS_FILL: begin
          if (mem_respcyc) begin
            r_line[{r_k, 6'b0} +: 64] <= mem_resp;
            r_k <= r_k + 3'd1;
            // Beat 0 is already in the buffer when beat 7 lands, so it can be presented next cycle.
            if (w_last) begin
              r_valid[w_idx] <= 1'b1;
              r_resp         <= r_line[63:0];
              r_resptag      <= r_tag;
              r_respcyc      <= 1'b1;
              r_state        <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          if (respack) begin
            r_k <= r_k + 3'd1;
            if (w_last) begin
              r_respcyc <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_resp <= r_line[{r_k + 3'd1, 6'b0} +: 64];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: randomized check of icache_responder against a direct-mapped cache model.
module tb_icache_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc;
  logic        reqack;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        respcyc;
  logic        respack;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        mem_reqcyc;
  logic        mem_reqack;
  logic [63:0] mem_req;
  logic [12:0] mem_reqtag;
  logic        mem_respcyc;
  logic        mem_respack;
  logic [63:0] mem_resp;

  int n_chk = 0;
  int n_err = 0;
  bit          mvalid [64];
  logic [63:0] mtag   [64];

  icache_responder dut (
    .clk(clk), .reset(reset),
    .reqcyc(reqcyc), .reqack(reqack), .req(req), .reqtag(reqtag),
    .respcyc(respcyc), .respack(respack), .resp(resp), .resptag(resptag),
    .mem_reqcyc(mem_reqcyc), .mem_reqack(mem_reqack), .mem_req(mem_req), .mem_reqtag(mem_reqtag),
    .mem_respcyc(mem_respcyc), .mem_respack(mem_respack), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tg, got, exp);
    end
  endtask

  // Memory contents are a fixed function of line address and beat number.
  function automatic logic [63:0] mword(input logic [63:0] la, input int k);
    if (la == 64'h1000_0040) return 64'(8'h11 * (k + 1));
    return la ^ (64'(k + 1) * 64'h0101_0101_0000_0000);
  endfunction

  // mode: 0 respack always high, 1 random respack, 2 stall beats 2 and 5 for 3 cycles each.
  // abort_mb >= 0 asserts reset when that many fill beats have been taken.
  task automatic xact(input logic [63:0] a, input logic [12:0] t, input int mode, input bit hold, input int abort_mb);
    logic [63:0] la;
    int idx, mb, cb, fd, nrc, st;
    bit miss, gr, in_fill, exp_rc, stall;
    la = a & ~64'h3f;
    idx = int'(a[11:6]);
    miss = !(mvalid[idx] && mtag[idx] == (a >> 12));
    mb = 0; cb = 0; fd = 0; nrc = 0; st = 0; gr = 0;
    @(negedge clk);
    reqcyc = 1'b1; req = a; reqtag = t;
    respack = 1'b0; mem_reqack = 1'b0; mem_respcyc = 1'b0;
    #1;
    chk("idle_respcyc", respcyc, 0);
    chk("reqack_idle", reqack, 1);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      in_fill = gr && mb < 8;
      reqcyc = hold ? 1'b1 : 1'($urandom_range(0, 1));
      req = {$urandom, $urandom};
      mem_reqack = mem_reqcyc && !gr && $urandom_range(0, 2) == 0;
      mem_respcyc = in_fill ? $urandom_range(0, 3) != 0 : 1'($urandom_range(0, 1));
      mem_resp = in_fill ? mword(la, mb) : {$urandom, $urandom};
      stall = mode == 2 && respcyc && (cb == 2 || cb == 5) && st < 3;
      respack = mode == 1 ? $urandom_range(0, 2) != 0 : !stall;
      if (stall) st++;
      if (abort_mb >= 0 && in_fill && mb == abort_mb) begin
        reqcyc = 1'b0; mem_respcyc = 1'b1; reset = 1'b1;
        #1;
        chk("rst_reqack", reqack, 0);
        chk("rst_respcyc", respcyc, 0);
        chk("rst_resp", resp, 0);
        chk("rst_resptag", resptag, 0);
        chk("rst_mem_reqcyc", mem_reqcyc, 0);
        chk("rst_mem_respack", mem_respack, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_reqtag", mem_reqtag, 0);
        for (int i = 0; i < 64; i++) mvalid[i] = 0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      #1;
      chk("reqack_busy", reqack, 0);
      chk("mem_reqcyc", mem_reqcyc, miss && c >= 2 && !gr);
      if (mem_reqcyc) begin
        chk("mem_req", mem_req, la);
        chk("mem_reqtag", mem_reqtag, t);
      end
      chk("mem_respack", mem_respack, in_fill && mem_respcyc);
      exp_rc = cb < 8 && (miss ? (mb == 8 && c > fd) : c >= 2);
      chk("respcyc", respcyc, exp_rc);
      if (respcyc) nrc++;
      if (exp_rc) begin
        chk("resp", resp, mword(la, cb));
        chk("resptag", resptag, t);
      end
      if (mem_reqcyc && mem_reqack) gr = 1;
      if (in_fill && mem_respcyc) begin
        mb++;
        if (mb == 8) begin
          fd = c;
          mvalid[idx] = 1;
          mtag[idx] = a >> 12;
        end
      end
      if (exp_rc && respack) begin
        cb++;
        st = 0;
      end
      if (cb == 8) begin
        if (mode == 2) chk("stall_respcyc_cycles", nrc, 14);
        chk("miss_seen", gr, miss);
        return;
      end
    end
    chk("timeout", 1, 0);
  endtask

  initial begin
    logic [63:0] a;
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 0;
      mtag[i] = '0;
    end
    reset = 1'b1;
    reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
    mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
    repeat (3) @(negedge clk);
    mem_respcyc = 1'b1;
    #1;
    chk("init_reqack", reqack, 0);
    chk("init_respcyc", respcyc, 0);
    chk("init_resp", resp, 0);
    chk("init_resptag", resptag, 0);
    chk("init_mem_reqcyc", mem_reqcyc, 0);
    chk("init_mem_respack", mem_respack, 0);
    chk("init_mem_req", mem_req, 0);
    chk("init_mem_reqtag", mem_reqtag, 0);
    @(negedge clk);
    reset = 1'b0; mem_respcyc = 1'b0;

    xact(64'h1000_0040, 13'h0380, 0, 0, -1);
    xact(64'h1000_0047, 13'h0381, 0, 0, -1);
    xact(64'h1000_0040, 13'h0382, 2, 0, -1);
    xact(64'h0000_0040, 13'h0383, 0, 0, -1);
    xact(64'h0000_1040, 13'h0384, 1, 0, -1);
    xact(64'h0000_0040, 13'h0385, 0, 0, -1);
    xact(64'h2000_0040, 13'h0386, 0, 0, 4);
    xact(64'h1000_0040, 13'h0387, 0, 0, -1);
    for (int n = 0; n < 6; n++) xact(64'h1000_0040 + 64'(n % 3) * 64'h1000, 13'(n), 0, 1, -1);
    for (int n = 0; n < 40; n++) begin
      a = (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) a[40] = 1'b1;
      xact(a, 13'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0 ? 3 : -1);
    end
    @(negedge clk);
    reqcyc = 1'b0;
    #1;
    chk("final_respcyc", respcyc, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder end of the core/cache request-response bus; the instruction fetch unit is the initiator.
- Accepts line-read requests (reqcyc/reqack) and returns the 64-byte aligned line as 8 contiguous 64-bit beats (respcyc/respack).
- Backed by a direct-mapped instruction cache.
- Misses are filled through an identical initiator-side bus toward memory.

Parameters:
LINES, 64, number of cache lines (power of 2, >=2); IDX=log2(LINES)
TAG_W, 13, width of reqtag/resptag
BEATS, 8, 64-bit beats per 64-byte line (fixed; not to be overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
reqcyc  in  1  core request valid
reqack  out  1  request accepted this cycle
req  in  64  request byte address; bits [5:0] ignored
reqtag  in  TAG_W  request tag {READ,MEMORY,INSTR,7'b0}
respcyc  out  1  response beat valid
respack  in  1  core accepts beat
resp  out  64  response beat data
resptag  out  TAG_W  tag of the request being answered
mem_reqcyc  out  1  fill request valid
mem_reqack  in  1  memory accepted fill request
mem_req  out  64  fill line address, bits [5:0]=0
mem_reqtag  out  TAG_W  copy of captured reqtag
mem_respcyc  in  1  memory fill beat valid
mem_respack  out  1  fill beat accepted
mem_resp  in  64  memory fill beat data

Behaviour:
- Reset (async, any state): state=IDLE; all valid bits cleared; reqack, respcyc, mem_reqcyc, mem_respack=0; resp, resptag, mem_req, mem_reqtag=0. Any in-flight fill is abandoned; the memory side shares the same reset.
- Address split: index=req[6 +: IDX]; tag=req[63:6+IDX]. The tag array holds 64-6-IDX bits plus 1 valid bit per line. The data array is LINES x 512 bits, written per beat.
- reqack = reqcyc && state==IDLE (combinational). At that edge, capture line address (req & ~63), reqtag and index. reqack is 0 in every other state. reqcyc outside IDLE is ignored and not queued.
- States:
  - IDLE: wait for reqack.
  - LOOKUP (1 cycle): synchronous read of tag/valid/data. Hit: copy the line into a 512-bit line buffer and go to RESPOND. Miss: go to MISS_REQ.
  - MISS_REQ: mem_reqcyc=1, mem_req=line address, mem_reqtag=captured tag. Hold until mem_reqack=1 is sampled, then go to MISS_FILL.
  - MISS_FILL: mem_respack=mem_respcyc. Beat k (k=0..7, counter) goes to line buffer bits [k*64 +: 64] and data array word k. After beat 7 the buffer is complete; write tag and set valid in the same cycle as beat 7, then go to RESPOND.
  - RESPOND: respcyc=1, resp=buffer[k*64 +: 64], resptag=captured tag. The counter advances on respcyc&&respack. With respack held high, respcyc stays high for 8 consecutive cycles and beat order is 0..7 (ascending address). respack=0 holds resp/resptag/k stable. After beat 7 is accepted, go to IDLE and drive respcyc low the next cycle.
- Latency:
  - Hit: request accepted at edge N, first beat visible in cycle N+2, last beat in cycle N+9 with continuous respack.
  - Miss: first core beat one cycle after the 8th mem beat is accepted.
- Beat counter is 3 bits, wraps 7->0, and is reset to 0 on entry to MISS_FILL and RESPOND.
- A new request can be accepted in the first IDLE cycle after the last beat, i.e. a 1-cycle bubble minimum.
- mem_respcyc outside MISS_FILL is ignored with mem_respack=0.
- Only reset invalidates lines; there is no write path from the core.

Test Plan:
- Cold miss: after reset, req=0x1000_0040 -> reqack same cycle; mem_req=0x1000_0040; memory returns beats 0x11..0x88 -> core receives 8 contiguous beats 0x11..0x88 with resptag=reqtag, then respcyc=0.
- Hit: repeat req=0x1000_0047 -> no mem_reqcyc; first beat 2 cycles after accept; data 0x11..0x88.
- Stall: on a hit, drop respack on beats 2 and 5 for 3 cycles each -> resp held stable; total respcyc-high cycles=14; no beat lost or duplicated.
- Conflict: LINES=64, fill 0x0000_0040, then request 0x0000_1040 (same index) -> miss and refill; then 0x0000_0040 -> miss again.
- Reset mid-operation: assert reset during MISS_FILL beat 4 -> all outputs 0 immediately; after release, 0x1000_0040 misses (valid cleared).
- Back-to-back: hold reqcyc high continuously -> reqack only in IDLE cycles, never during LOOKUP/MISS_*/RESPOND; each accepted request gets exactly 8 beats.
